imm_extend_pipe: RTL and testbench
==================================

Name: imm_extend_pipe

Overview:
Parametrised, pipelined immediate generator for the 32-bit core. It replaces the single-cycle combinational extender with a registered stage that has valid/ready handshakes on both sides. The stage adds ARM-style rotated data-processing immediates, signed memory offsets, split halfword offsets and illegal-mode flagging. It sits between decode and the operand mux; an optional iterative rotator trades latency for area.

Parameters:
DATA_W, 32, output width; legal range 32..64. Results are sign- or zero-extended to DATA_W.
ITERATIVE, 0, 0 = single-cycle barrel rotate; 1 = rotate 2 bits per cycle under an FSM.

Ports:
clk  in  1  core clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
flush  in  1  synchronous pipeline flush from hazard unit
in_valid  in  1  Instruction/ImmSrc valid
in_ready  out  1  stage can accept
Instruction  in  24  instruction bits [23:0]
ImmSrc  in  3  immediate mode select
out_valid  out  1  ExtImm valid
out_ready  in  1  consumer accepts
ExtImm  out  DATA_W  extended immediate
ImmErr  out  1  illegal ImmSrc for the current output

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, ExtImm=0, ImmErr=0, FSM=IDLE, rotate counter=0. in_ready=1 after reset.
- Modes (I = Instruction):
  - 000 DP: 32-bit value {24'b0,I[7:0]} rotated right by 2*I[11:8], then zero-extended to DATA_W.
  - 001 MEM: zero-extend I[11:0].
  - 010 BR: sign-extend {I[23:0],2'b00} from bit 25.
  - 011 MEMS: sign-extend I[11:0] from bit 11.
  - 100 HALF: zero-extend {I[11:8],I[3:0]}.
  - 101..111: ExtImm=0 and ImmErr=1. The transfer still completes normally.
- Handshake:
  - Transfer occurs on valid&&ready.
  - While out_valid && !out_ready, ExtImm and ImmErr are held stable.
  - out_valid never drops without a transfer, except on flush.
- ITERATIVE=0:
  - in_ready = !out_valid || out_ready (combinational).
  - Latency 1 cycle; accepted at edge N, visible after edge N.
  - Full throughput: back-to-back transfers every cycle when out_ready=1.
- ITERATIVE=1, FSM states IDLE, ROT, DONE:
  - IDLE: in_ready=1. On accept:
    - DP with I[11:8]!=0: load {24'b0,I[7:0]}, counter=I[11:8], go to ROT.
    - Otherwise: compute the result, go to DONE.
  - ROT: in_ready=0. Each cycle, rotate the 32-bit working value right by 2 and decrement the counter. When counter==1, load the result and go to DONE.
  - DONE: out_valid=1.
    - If out_ready: go to IDLE. in_ready is 0 in DONE, so there is no bubble-free overlap; throughput is at most one per 2 cycles.
    - Latency: 1 + I[11:8] cycles for DP, 1 cycle otherwise.
- flush:
  - Highest priority. On the next edge: out_valid=0, FSM=IDLE, counter=0.
  - Any input accepted in the flush cycle is discarded.
  - ExtImm keeps its last value; its content is don't-care while out_valid=0.
- Width rules:
  - Rotation is always performed on 32 bits, independent of DATA_W.
  - Sign extension replicates bit 25 (BR) or bit 11 (MEMS) up to DATA_W-1.
- Boundary cases:
  - Rotate amount 0: no rotation; 1 cycle even with ITERATIVE=1.
  - Rotate amount 15: ROR 30.
  - Reset mid-rotation: abort immediately; no output is produced.

Decomposition:
- Shared package imm_pkg:
  - ImmSrc encodings as localparams: IMM_DP, IMM_MEM, IMM_BR, IMM_MEMS, IMM_HALF.
  - FSM state encoding.
  - Field position constants: ROT_LSB=8, IMM8_MSB=7.
- Sub-module imm_decode_comb: pure combinational mode decode and extension, producing the pre-rotate value, rotate amount and ImmErr.
- imm_extend_pipe itself owns the handshake registers, the FSM and the rotator.

Test Plan:
- Mode DP, I[11:0]=0x4FF, ITERATIVE=0 -> ExtImm=0xFF000000 one cycle after accept. With ITERATIVE=1 -> same value after 5 cycles, in_ready=0 during ROT.
- Mode BR, I=0xFFFFFE -> ExtImm=0xFFFFFFF8; with DATA_W=64 -> 0xFFFFFFFFFFFFFFF8. Mode BR, I=0x000010 -> 0x00000040.
- Mode MEM, I[11:0]=0xABC -> 0x00000ABC.
- Mode MEMS, I[11:0]=0x800 -> 0xFFFFF800.
- Mode HALF, I[11:8]=0xA and I[3:0]=0x5 -> 0x000000A5.
- ImmSrc=111 -> ExtImm=0, ImmErr=1, transfer completes.
- Backpressure: hold out_ready=0 for 3 cycles with in_valid=1.
  - Expect ExtImm stable and in_ready=0 (ITERATIVE=0: in_ready low while the output is full).
  - Release out_ready -> exactly one transfer per cycle, in order, no loss or duplication.
- Flush during ROT (DP, rot=15, flush at cycle 3) -> out_valid stays 0, FSM back to IDLE next cycle, the next MEM request completes in 1 cycle. Assert rst_n low mid-ROT -> all outputs 0 immediately.

Source files
------------

// File: rtl/imm_extend_pipe_pkg.sv
// Shared definitions for the pipelined immediate generator.
// Holds the mode encodings, FSM state type, field positions and the 32-bit rotate helper.
package imm_pkg;

  localparam logic [2:0] IMM_DP   = 3'b000;
  localparam logic [2:0] IMM_MEM  = 3'b001;
  localparam logic [2:0] IMM_BR   = 3'b010;
  localparam logic [2:0] IMM_MEMS = 3'b011;
  localparam logic [2:0] IMM_HALF = 3'b100;

  localparam int ROT_LSB  = 8;
  localparam int IMM8_MSB = 7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ROT  = 2'b01,
    ST_DONE = 2'b10
  } imm_state_e;

  // Rotation is always 32 bits wide, whatever the output width.
  function automatic logic [31:0] ror32(input logic [31:0] val, input logic [4:0] amt);
    logic [63:0] dbl;
    dbl = {val, val} >> amt;
    return dbl[31:0];
  endfunction

endpackage

// File: rtl/imm_extend_pipe_if.sv
// Handshake bundle between decode (master) and the immediate stage (slave).
// Carries both the request side and the result side of the stage.
interface imm_extend_pipe_if #(
  parameter int DATA_W = 32
);

  logic              in_valid;
  logic              in_ready;
  logic [23:0]       Instruction;
  logic [2:0]        ImmSrc;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] ExtImm;
  logic              ImmErr;

  modport slave (
    input  in_valid, Instruction, ImmSrc, out_ready,
    output in_ready, out_valid, ExtImm, ImmErr
  );

  modport master (
    output in_valid, Instruction, ImmSrc, out_ready,
    input  in_ready, out_valid, ExtImm, ImmErr
  );

endinterface

// File: rtl/imm_extend_pipe_decode.sv
// Combinational mode decode: extended value for non-DP modes, the unrotated
// 8-bit payload and rotate count for DP, and the illegal-mode flag.
module imm_decode_comb
  import imm_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [23:0]       instr_i,
  input  logic [2:0]        imm_src_i,
  output logic [DATA_W-1:0] base_o,
  output logic [3:0]        rot_o,
  output logic              is_dp_o,
  output logic              err_o
);

  // Per-mode extension; illegal modes yield zero with the error flag set.
  always_comb begin
    base_o  = '0;
    rot_o   = 4'd0;
    is_dp_o = 1'b0;
    err_o   = 1'b0;
    case (imm_src_i)
      IMM_DP: begin
        base_o[IMM8_MSB:0] = instr_i[IMM8_MSB:0];
        rot_o              = instr_i[ROT_LSB+3:ROT_LSB];
        is_dp_o            = 1'b1;
      end
      IMM_MEM: begin
        base_o[11:0] = instr_i[11:0];
      end
      IMM_BR: begin
        base_o = {{(DATA_W-26){instr_i[23]}}, instr_i, 2'b00};
      end
      IMM_MEMS: begin
        base_o = {{(DATA_W-12){instr_i[11]}}, instr_i[11:0]};
      end
      IMM_HALF: begin
        base_o[7:0] = {instr_i[11:8], instr_i[3:0]};
      end
      default: begin
        err_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/imm_extend_pipe.sv
// Registered immediate-generation stage with valid/ready on both sides.
// ITERATIVE=0 rotates in one cycle; ITERATIVE=1 rotates 2 bits per cycle under an FSM.
module imm_extend_pipe
  import imm_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ITERATIVE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  imm_extend_pipe_if.slave bus
);

  logic [DATA_W-1:0] dec_base_s;
  logic [3:0]        dec_rot_s;
  logic              dec_is_dp_s;
  logic              dec_err_s;
  logic [DATA_W-1:0] res_s;
  logic              in_ready_s;
  logic              out_valid_q;
  logic [DATA_W-1:0] ext_q;
  logic              err_q;

  imm_decode_comb #(
    .DATA_W (DATA_W)
  ) u_decode (
    .instr_i   (bus.Instruction),
    .imm_src_i (bus.ImmSrc),
    .base_o    (dec_base_s),
    .rot_o     (dec_rot_s),
    .is_dp_o   (dec_is_dp_s),
    .err_o     (dec_err_s)
  );

  // Single-cycle result: DP payload rotated by twice the 4-bit field.
  always_comb begin
    res_s = dec_base_s;
    if (dec_is_dp_s) begin
      res_s = DATA_W'(ror32(dec_base_s[31:0], {dec_rot_s, 1'b0}));
    end else begin
      res_s = dec_base_s;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_q;
  assign bus.ExtImm    = ext_q;
  assign bus.ImmErr    = err_q;

  generate
    if (ITERATIVE == 0) begin : g_single
      logic accept_s;

      assign in_ready_s = !out_valid_q || bus.out_ready;
      assign accept_s   = bus.in_valid && in_ready_s;

      // Output register: load on accept, drain on consume, drop on flush.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_valid_q <= 1'b0;
          ext_q       <= '0;
          err_q       <= 1'b0;
        end else if (flush) begin
          out_valid_q <= 1'b0;
        end else if (accept_s) begin
          out_valid_q <= 1'b1;
          ext_q       <= res_s;
          err_q       <= dec_err_s;
        end else if (bus.out_ready) begin
          out_valid_q <= 1'b0;
        end
      end
    end else begin : g_iter
      imm_state_e  state_q;
      logic [3:0]  cnt_q;
      logic [31:0] work_q;
      logic [31:0] work_d;

      assign work_d     = ror32(work_q, 5'd2);
      assign in_ready_s = (state_q == ST_IDLE);

      // FSM: IDLE accepts, ROT steps the rotator, DONE presents the result.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state_q     <= ST_IDLE;
          cnt_q       <= 4'd0;
          work_q      <= 32'd0;
          out_valid_q <= 1'b0;
          ext_q       <= '0;
          err_q       <= 1'b0;
        end else if (flush) begin
          state_q     <= ST_IDLE;
          cnt_q       <= 4'd0;
          out_valid_q <= 1'b0;
        end else begin
          case (state_q)
            ST_IDLE: begin
              if (bus.in_valid) begin
                if (dec_is_dp_s && (dec_rot_s != 4'd0)) begin
                  work_q  <= dec_base_s[31:0];
                  cnt_q   <= dec_rot_s;
                  state_q <= ST_ROT;
                end else begin
                  ext_q       <= res_s;
                  err_q       <= dec_err_s;
                  out_valid_q <= 1'b1;
                  state_q     <= ST_DONE;
                end
              end
            end
            ST_ROT: begin
              work_q <= work_d;
              cnt_q  <= cnt_q - 4'd1;
              // Last step: the rotated value goes straight to the output.
              if (cnt_q == 4'd1) begin
                ext_q       <= DATA_W'(work_d);
                err_q       <= 1'b0;
                out_valid_q <= 1'b1;
                state_q     <= ST_DONE;
              end
            end
            ST_DONE: begin
              if (bus.out_ready) begin
                out_valid_q <= 1'b0;
                state_q     <= ST_IDLE;
              end
            end
            default: begin
              state_q     <= ST_IDLE;
              cnt_q       <= 4'd0;
              out_valid_q <= 1'b0;
            end
          endcase
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed bench for imm_extend_pipe: single-cycle 32-bit, iterative 32-bit
// and single-cycle 64-bit instances checked against hand-computed values.
module tb_imm_extend_pipe;

  typedef struct {
    int          w;
    logic [2:0]  s;
    logic [23:0] ins;
    logic [63:0] v;
    logic        e;
    int          lat;
  } vec_t;

  logic clk;
  logic rst_n;
  logic flush;
  int   n_cmp;
  int   n_err;

  imm_extend_pipe_if #(.DATA_W(32)) if0 ();
  imm_extend_pipe_if #(.DATA_W(32)) if1 ();
  imm_extend_pipe_if #(.DATA_W(64)) if2 ();

  imm_extend_pipe #(.DATA_W(32), .ITERATIVE(0)) u0 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(if0));
  imm_extend_pipe #(.DATA_W(32), .ITERATIVE(1)) u1 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(if1));
  imm_extend_pipe #(.DATA_W(64), .ITERATIVE(0)) u2 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(if2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input int w, input logic v, input logic [2:0] s, input logic [23:0] ins, input logic r);
    case (w)
      0: begin if0.in_valid = v; if0.ImmSrc = s; if0.Instruction = ins; if0.out_ready = r; end
      1: begin if1.in_valid = v; if1.ImmSrc = s; if1.Instruction = ins; if1.out_ready = r; end
      default: begin if2.in_valid = v; if2.ImmSrc = s; if2.Instruction = ins; if2.out_ready = r; end
    endcase
  endtask

  function automatic logic rd_in_ready(input int w);
    case (w)
      0: return if0.in_ready;
      1: return if1.in_ready;
      default: return if2.in_ready;
    endcase
  endfunction

  function automatic logic rd_out_valid(input int w);
    case (w)
      0: return if0.out_valid;
      1: return if1.out_valid;
      default: return if2.out_valid;
    endcase
  endfunction

  function automatic logic [63:0] rd_ext(input int w);
    case (w)
      0: return {32'h0, if0.ExtImm};
      1: return {32'h0, if1.ExtImm};
      default: return if2.ExtImm;
    endcase
  endfunction

  function automatic logic rd_err(input int w);
    case (w)
      0: return if0.ImmErr;
      1: return if1.ImmErr;
      default: return if2.ImmErr;
    endcase
  endfunction

  // One request with out_ready high; lat counts edges from accept edge to output valid.
  task automatic xfer(input int w, input logic [2:0] s, input logic [23:0] ins,
                      output logic [63:0] val, output logic err, output int lat);
    int guard;
    guard = 0;
    drive(w, 1'b1, s, ins, 1'b1);
    while (!rd_in_ready(w) && guard < 40) begin
      @(posedge clk); #1;
      guard++;
    end
    @(posedge clk); #1;
    drive(w, 1'b0, s, ins, 1'b1);
    lat = 1;
    while (!rd_out_valid(w) && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    val = rd_ext(w);
    err = rd_err(w);
    @(posedge clk); #1;
  endtask

  task automatic run_table(input string name, input vec_t tbl[$]);
    logic [63:0] val;
    logic        err;
    int          lat;
    for (int i = 0; i < tbl.size(); i++) begin
      xfer(tbl[i].w, tbl[i].s, tbl[i].ins, val, err, lat);
      n_cmp++;
      if (val !== tbl[i].v) begin
        $display("FAIL %s[%0d] ExtImm: got %h want %h", name, i, val, tbl[i].v); n_err++;
      end
      n_cmp++;
      if (err !== tbl[i].e) begin
        $display("FAIL %s[%0d] ImmErr: got %b want %b", name, i, err, tbl[i].e); n_err++;
      end
      n_cmp++;
      if (lat != tbl[i].lat) begin
        $display("FAIL %s[%0d] latency: got %0d want %0d", name, i, lat, tbl[i].lat); n_err++;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    flush = 1'b0;
    for (int w = 0; w < 3; w++) drive(w, 1'b0, 3'b000, 24'h0, 1'b1);
    #2;
    for (int w = 0; w < 3; w++) begin
      n_cmp++;
      if (rd_out_valid(w) !== 1'b0 || rd_ext(w) !== 64'h0 || rd_err(w) !== 1'b0) begin
        $display("FAIL reset_out[%0d]: got v=%b x=%h e=%b want 0/0/0", w, rd_out_valid(w), rd_ext(w), rd_err(w)); n_err++;
      end
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    for (int w = 0; w < 3; w++) begin
      n_cmp++;
      if (rd_in_ready(w) !== 1'b1) begin
        $display("FAIL reset_in_ready[%0d]: got %b want 1", w, rd_in_ready(w)); n_err++;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_dp();
    vec_t t[$];
    t.push_back('{0, 3'b000, 24'h0004FF, 64'h00000000FF000000, 1'b0, 1});
    t.push_back('{1, 3'b000, 24'h0004FF, 64'h00000000FF000000, 1'b0, 5});
    t.push_back('{2, 3'b000, 24'h0004FF, 64'h00000000FF000000, 1'b0, 1});
    t.push_back('{1, 3'b000, 24'h0000AB, 64'h00000000000000AB, 1'b0, 1});
    t.push_back('{0, 3'b000, 24'h000FC1, 64'h0000000000000304, 1'b0, 1});
    t.push_back('{1, 3'b000, 24'h000FC1, 64'h0000000000000304, 1'b0, 16});
    t.push_back('{0, 3'b000, 24'h0001FF, 64'h00000000C000003F, 1'b0, 1});
    t.push_back('{1, 3'b000, 24'h0001FF, 64'h00000000C000003F, 1'b0, 2});
    run_table("dp", t);
  endtask

  task automatic test_modes();
    vec_t t[$];
    t.push_back('{0, 3'b010, 24'hFFFFFE, 64'h00000000FFFFFFF8, 1'b0, 1});
    t.push_back('{2, 3'b010, 24'hFFFFFE, 64'hFFFFFFFFFFFFFFF8, 1'b0, 1});
    t.push_back('{0, 3'b010, 24'h000010, 64'h0000000000000040, 1'b0, 1});
    t.push_back('{2, 3'b010, 24'h000010, 64'h0000000000000040, 1'b0, 1});
    t.push_back('{0, 3'b001, 24'h000ABC, 64'h0000000000000ABC, 1'b0, 1});
    t.push_back('{0, 3'b001, 24'hFFFABC, 64'h0000000000000ABC, 1'b0, 1});
    t.push_back('{0, 3'b011, 24'h000800, 64'h00000000FFFFF800, 1'b0, 1});
    t.push_back('{2, 3'b011, 24'h000800, 64'hFFFFFFFFFFFFF800, 1'b0, 1});
    t.push_back('{0, 3'b011, 24'h0007FF, 64'h00000000000007FF, 1'b0, 1});
    t.push_back('{1, 3'b011, 24'h000800, 64'h00000000FFFFF800, 1'b0, 1});
    t.push_back('{0, 3'b100, 24'h000A05, 64'h00000000000000A5, 1'b0, 1});
    t.push_back('{0, 3'b100, 24'h000AF5, 64'h00000000000000A5, 1'b0, 1});
    t.push_back('{0, 3'b111, 24'h123456, 64'h0, 1'b1, 1});
    t.push_back('{0, 3'b101, 24'hFFFFFF, 64'h0, 1'b1, 1});
    t.push_back('{1, 3'b111, 24'hFFFFFF, 64'h0, 1'b1, 1});
    t.push_back('{2, 3'b110, 24'hFFFFFF, 64'h0, 1'b1, 1});
    run_table("modes", t);
  endtask

  task automatic test_iter_ready();
    int bad;
    bad = 0;
    drive(1, 1'b1, 3'b000, 24'h0004FF, 1'b0);
    @(posedge clk); #1;
    drive(1, 1'b0, 3'b000, 24'h0, 1'b0);
    for (int c = 0; c < 4; c++) begin
      if (if1.in_ready !== 1'b0 || if1.out_valid !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (bad != 0) begin
      $display("FAIL iter_rot_busy: got %0d cycles with in_ready/out_valid high want 0", bad); n_err++;
    end
    n_cmp++;
    if (if1.out_valid !== 1'b1 || if1.ExtImm !== 32'hFF000000) begin
      $display("FAIL iter_done: got v=%b x=%h want 1/ff000000", if1.out_valid, if1.ExtImm); n_err++;
    end
    n_cmp++;
    if (if1.in_ready !== 1'b0) begin
      $display("FAIL iter_done_in_ready: got %b want 0", if1.in_ready); n_err++;
    end
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (if1.out_valid !== 1'b1 || if1.ExtImm !== 32'hFF000000) begin
      $display("FAIL iter_hold: got v=%b x=%h want 1/ff000000", if1.out_valid, if1.ExtImm); n_err++;
    end
    if1.out_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (if1.out_valid !== 1'b0 || if1.in_ready !== 1'b1) begin
      $display("FAIL iter_drain: got v=%b r=%b want 0/1", if1.out_valid, if1.in_ready); n_err++;
    end
  endtask

  task automatic test_back_to_back();
    drive(0, 1'b1, 3'b001, 24'h000001, 1'b1);
    for (int k = 1; k <= 4; k++) begin
      if0.Instruction = 24'(k);
      @(posedge clk); #1;
      n_cmp++;
      if (if0.out_valid !== 1'b1 || if0.ExtImm !== 32'(k)) begin
        $display("FAIL b2b[%0d]: got v=%b x=%h want 1/%h", k, if0.out_valid, if0.ExtImm, 32'(k)); n_err++;
      end
    end
    drive(0, 1'b0, 3'b001, 24'h0, 1'b1);
    @(posedge clk); #1;
    n_cmp++;
    if (if0.out_valid !== 1'b0) begin
      $display("FAIL b2b_end: got out_valid=%b want 0", if0.out_valid); n_err++;
    end
  endtask

  task automatic test_backpressure();
    int bad;
    bad = 0;
    drive(0, 1'b1, 3'b001, 24'h000111, 1'b0);
    @(posedge clk); #1;
    if0.Instruction = 24'h000222;
    for (int c = 0; c < 3; c++) begin
      if (if0.in_ready !== 1'b0 || if0.out_valid !== 1'b1 || if0.ExtImm !== 32'h111) bad++;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (bad != 0) begin
      $display("FAIL bp_hold: got %0d unstable cycles want 0", bad); n_err++;
    end
    if0.out_ready = 1'b1;
    #1;
    n_cmp++;
    if (if0.in_ready !== 1'b1 || if0.ExtImm !== 32'h111) begin
      $display("FAIL bp_release: got r=%b x=%h want 1/111", if0.in_ready, if0.ExtImm); n_err++;
    end
    @(posedge clk); #1;
    n_cmp++;
    if (if0.out_valid !== 1'b1 || if0.ExtImm !== 32'h222) begin
      $display("FAIL bp_next0: got v=%b x=%h want 1/222", if0.out_valid, if0.ExtImm); n_err++;
    end
    if0.Instruction = 24'h000333;
    @(posedge clk); #1;
    n_cmp++;
    if (if0.out_valid !== 1'b1 || if0.ExtImm !== 32'h333) begin
      $display("FAIL bp_next1: got v=%b x=%h want 1/333", if0.out_valid, if0.ExtImm); n_err++;
    end
    drive(0, 1'b0, 3'b001, 24'h0, 1'b1);
    @(posedge clk); #1;
    n_cmp++;
    if (if0.out_valid !== 1'b0) begin
      $display("FAIL bp_end: got out_valid=%b want 0", if0.out_valid); n_err++;
    end
  endtask

  task automatic test_flush();
    int          seen;
    logic [63:0] val;
    logic        err;
    int          lat;
    seen = 0;
    drive(1, 1'b1, 3'b000, 24'h000FC1, 1'b1);
    @(posedge clk); #1;
    drive(1, 1'b0, 3'b000, 24'h0, 1'b1);
    repeat (2) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    n_cmp++;
    if (if1.out_valid !== 1'b0 || if1.in_ready !== 1'b1) begin
      $display("FAIL flush_idle: got v=%b r=%b want 0/1", if1.out_valid, if1.in_ready); n_err++;
    end
    for (int c = 0; c < 20; c++) begin
      if (if1.out_valid === 1'b1) seen++;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (seen != 0) begin
      $display("FAIL flush_no_output: got %0d valid cycles want 0", seen); n_err++;
    end
    xfer(1, 3'b001, 24'h000123, val, err, lat);
    n_cmp++;
    if (val !== 64'h123 || lat != 1) begin
      $display("FAIL flush_next_mem: got x=%h lat=%0d want 123/1", val, lat); n_err++;
    end
    drive(0, 1'b1, 3'b001, 24'h000555, 1'b1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    drive(0, 1'b0, 3'b001, 24'h0, 1'b1);
    n_cmp++;
    if (if0.out_valid !== 1'b0) begin
      $display("FAIL flush_discard: got out_valid=%b want 0", if0.out_valid); n_err++;
    end
  endtask

  task automatic test_reset_mid_rot();
    logic [63:0] val;
    logic        err;
    int          lat;
    drive(1, 1'b1, 3'b000, 24'h000FC1, 1'b1);
    @(posedge clk); #1;
    drive(1, 1'b0, 3'b000, 24'h0, 1'b1);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (if1.out_valid !== 1'b0 || if1.ExtImm !== 32'h0 || if1.ImmErr !== 1'b0 || if1.in_ready !== 1'b1) begin
      $display("FAIL rst_mid_rot: got v=%b x=%h e=%b r=%b want 0/0/0/1",
               if1.out_valid, if1.ExtImm, if1.ImmErr, if1.in_ready); n_err++;
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    xfer(1, 3'b001, 24'h00000F, val, err, lat);
    n_cmp++;
    if (val !== 64'hF || lat != 1) begin
      $display("FAIL rst_after_mem: got x=%h lat=%0d want f/1", val, lat); n_err++;
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_dp();
    test_modes();
    test_iter_ready();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_reset_mid_rot();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1);
  end

endmodule
